// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: per-requester operand handshake plus one response slot.
interface adder_arbiter_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]       io_req_valid;
    logic [NREQ-1:0]       io_req_ready;
    logic [NREQ*WIDTH-1:0] io_req_lhs;
    logic [NREQ*WIDTH-1:0] io_req_rhs;
    logic [NREQ-1:0]       io_req_cin;
    logic [NREQ-1:0]       io_req_last;
    logic                  io_rsp_valid;
    logic                  io_rsp_ready;
    logic [IDW-1:0]        io_rsp_id;
    logic [WIDTH-1:0]      io_rsp_out;
    logic                  io_rsp_cout;
    logic                  io_busy;

    modport master (
        output io_req_valid, io_req_lhs, io_req_rhs, io_req_cin, io_req_last, io_rsp_ready,
        input  io_req_ready, io_rsp_valid, io_rsp_id, io_rsp_out, io_rsp_cout, io_busy
    );

    modport slave (
        input  io_req_valid, io_req_lhs, io_req_rhs, io_req_cin, io_req_last, io_rsp_ready,
        output io_req_ready, io_rsp_valid, io_rsp_id, io_rsp_out, io_rsp_cout, io_busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin shared add-with-carry unit with a single registered response slot.
// Optional ADDER_ARB_CHAIN_EN: io_req_last locks the arbiter for multi-word carry-chained adds.
module adder_arbiter #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned NREQ  = 4
) (
    input  logic           clk,
    input  logic           reset,
    adder_arbiter_if.slave io
);
    localparam int unsigned IDW = $clog2(NREQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e            state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]  cand;
    logic             found;
    logic [IDW-1:0]   gnt_idx;
    logic             can_accept;
    logic             transfer;
    logic             advance;
    logic [WIDTH-1:0] lhs_sel, rhs_sel;
    logic             cin_raw, cin_sel;
    logic             last_sel;
    logic [WIDTH:0]   sum;

    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_out_q;
    logic             rsp_cout_q;

`ifdef ADDER_ARB_CHAIN_EN
    logic           lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           carry_q, carry_d;

    // While locked only the owning requester is eligible.
    always_comb begin
        cand = io.io_req_valid;
        if (lock_q) begin
            cand = '0;
            cand[lock_id_q] = io.io_req_valid[lock_id_q];
        end
    end

    assign cin_sel = lock_q ? carry_q : cin_raw;
    assign advance = last_sel;

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        carry_d   = carry_q;
        if (transfer) begin
            lock_d    = !last_sel;
            lock_id_d = gnt_idx;
            carry_d   = sum[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            carry_q   <= carry_d;
        end
    end
`else
    logic unused_last;

    assign cand        = io.io_req_valid;
    assign cin_sel     = cin_raw;
    assign advance     = 1'b1;
    assign unused_last = ^{io.io_req_last, last_sel};
`endif

    // First eligible requester scanning cyclically from the pointer.
    always_comb begin : pick_blk
        int unsigned idx;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && cand[IDW'(idx)]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        lhs_sel  = '0;
        rhs_sel  = '0;
        cin_raw  = 1'b0;
        last_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                lhs_sel  = io.io_req_lhs[i*WIDTH +: WIDTH];
                rhs_sel  = io.io_req_rhs[i*WIDTH +: WIDTH];
                cin_raw  = io.io_req_cin[i];
                last_sel = io.io_req_last[i];
            end
        end
    end

    assign sum = {1'b0, lhs_sel} + {1'b0, rhs_sel} + (WIDTH+1)'(cin_sel);

    // Slot state, grant and pointer update.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        io.io_req_ready = '0;
        transfer        = 1'b0;
        can_accept      = (state_q == EMPTY) || io.io_rsp_ready;

        if (reset && can_accept && found) begin
            transfer                 = 1'b1;
            io.io_req_ready[gnt_idx] = 1'b1;
        end

        if (state_q == EMPTY) begin
            if (transfer) state_d = FULL;
        end else begin
            if (io.io_rsp_ready && !transfer) state_d = EMPTY;
        end

        if (transfer && advance) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_out_q  <= '0;
            rsp_cout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (transfer) begin
                rsp_id_q   <= gnt_idx;
                rsp_out_q  <= sum[WIDTH-1:0];
                rsp_cout_q <= sum[WIDTH];
            end
        end
    end

    assign io.io_rsp_valid = (state_q == FULL);
    assign io.io_busy      = (state_q == FULL);
    assign io.io_rsp_id    = rsp_id_q;
    assign io.io_rsp_out   = rsp_out_q;
    assign io.io_rsp_cout  = rsp_cout_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed + random bench for adder_arbiter against a behavioural slot/round-robin model.
module tb_adder_arbiter;
    localparam int unsigned WIDTH = 2;
    localparam int unsigned NREQ  = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    adder_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) io ();

    adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    // stimulus
    int            s_lhs [NREQ];
    int            s_rhs [NREQ];
    bit [NREQ-1:0] s_valid;
    bit [NREQ-1:0] s_cin;
    bit [NREQ-1:0] s_last;
    bit            s_rdy;

    // reference model
    bit m_valid;
    int m_id, m_out, m_cout, m_ptr;
    bit m_lock;
    int m_lock_id, m_carry;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            io.io_req_lhs[i*WIDTH +: WIDTH] = WIDTH'(s_lhs[i]);
            io.io_req_rhs[i*WIDTH +: WIDTH] = WIDTH'(s_rhs[i]);
        end
        io.io_req_valid = s_valid;
        io.io_req_cin   = s_cin;
        io.io_req_last  = s_last;
        io.io_rsp_ready = s_rdy;
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_ptr     = 0;
        m_lock    = 1'b0;
        m_lock_id = 0;
        m_carry   = 0;
    endtask

    function automatic int exp_grant();
        if (m_valid && !s_rdy) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
`ifdef ADDER_ARB_CHAIN_EN
            if (m_lock && idx != m_lock_id) continue;
`endif
            if (s_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: drive, check grant, update model at the edge, check response on the falling edge.
    task automatic cycle();
        int g, sum, cin;
        apply();
        #1;
        g = exp_grant();
        chk("req_ready", 64'(io.io_req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        @(posedge clk);
        if (m_valid && s_rdy) m_valid = 1'b0;
        if (g >= 0) begin
            cin = int'(s_cin[g]);
`ifdef ADDER_ARB_CHAIN_EN
            if (m_lock) cin = m_carry;
`endif
            sum     = s_lhs[g] + s_rhs[g] + cin;
            m_valid = 1'b1;
            m_id    = g;
            m_out   = sum % (1 << WIDTH);
            m_cout  = sum / (1 << WIDTH);
`ifdef ADDER_ARB_CHAIN_EN
            if (!s_last[g]) begin
                m_lock    = 1'b1;
                m_lock_id = g;
                m_carry   = m_cout;
            end else begin
                m_lock = 1'b0;
                m_ptr  = (g + 1) % NREQ;
            end
`else
            m_ptr = (g + 1) % NREQ;
`endif
        end
        @(negedge clk);
        chk("rsp_valid", 64'(io.io_rsp_valid), 64'(m_valid));
        chk("busy", 64'(io.io_busy), 64'(m_valid));
        if (m_valid) begin
            chk("rsp_id", 64'(io.io_rsp_id), 64'(m_id));
            chk("rsp_out", 64'(io.io_rsp_out), 64'(m_out));
            chk("rsp_cout", 64'(io.io_rsp_cout), 64'(m_cout));
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NREQ; i++) begin
            s_lhs[i] = 0;
            s_rhs[i] = 0;
        end
        s_valid = '0;
        s_cin   = '0;
        s_last  = '1;
        s_rdy   = 1'b1;
    endtask

    // Synchronous-looking reset sequence, entered and left on a falling edge.
    task automatic do_reset();
        reset   = 1'b0;
        s_valid = '1;
        apply();
        #1;
        chk("rst_req_ready", 64'(io.io_req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(io.io_rsp_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_id", 64'(io.io_rsp_id), 64'd0);
        chk("rst_rsp_out", 64'(io.io_rsp_out), 64'd0);
        chk("rst_rsp_cout", 64'(io.io_rsp_cout), 64'd0);
        chk("rst_busy", 64'(io.io_busy), 64'd0);
        reset = 1'b1;
        model_reset();
        clear_stim();
    endtask

    initial begin
        reset = 1'b0;
        clear_stim();
        model_reset();
        apply();
        @(negedge clk);
        do_reset();

        // single request: 1+2+0
        s_valid  = 4'b0001;
        s_lhs[0] = 1;
        s_rhs[0] = 2;
        cycle();
        chk("first_out", 64'(io.io_rsp_out), 64'd3);
        chk("first_id", 64'(io.io_rsp_id), 64'd0);

        // round robin from a fresh pointer, no bubbles
        do_reset();
        s_valid = '1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                s_lhs[i] = int'($urandom_range(0, 3));
                s_rhs[i] = int'($urandom_range(0, 3));
            end
            s_cin = NREQ'($urandom);
            cycle();
            chk("rr_id", 64'(io.io_rsp_id), 64'(k % NREQ));
        end

        // backpressure: slot holds id2 3+2+0
        s_valid = '0;
        cycle();
        s_valid  = 4'b0100;
        s_lhs[2] = 3;
        s_rhs[2] = 2;
        s_cin    = '0;
        s_rdy    = 1'b0;
        cycle();
        chk("bp_out", 64'(io.io_rsp_out), 64'd1);
        chk("bp_cout", 64'(io.io_rsp_cout), 64'd1);
        s_valid = '1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold_id", 64'(io.io_rsp_id), 64'd2);
        end
        s_rdy = 1'b1;
        apply();
        #1;
        chk("bp_release_grant", 64'(io.io_req_ready), 64'b1000);
        cycle();

        // overflow and carry-only sums
        s_valid  = 4'b0001;
        s_lhs[0] = 3;
        s_rhs[0] = 3;
        s_cin    = 4'b0001;
        cycle();
        chk("ovf_out", 64'(io.io_rsp_out), 64'd3);
        chk("ovf_cout", 64'(io.io_rsp_cout), 64'd1);
        s_lhs[0] = 0;
        s_rhs[0] = 0;
        cycle();
        chk("cin_out", 64'(io.io_rsp_out), 64'd1);
        chk("cin_cout", 64'(io.io_rsp_cout), 64'd0);

        // random traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                s_lhs[i] = int'($urandom_range(0, 3));
                s_rhs[i] = int'($urandom_range(0, 3));
            end
            s_valid = NREQ'($urandom);
            s_cin   = NREQ'($urandom);
            s_last  = NREQ'($urandom) | NREQ'($urandom);
            s_rdy   = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // asynchronous reset while full with requests pending
        clear_stim();
        s_valid = 4'b0010;
        s_rdy   = 1'b0;
        cycle();
        s_valid = '1;
        apply();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rsp_valid", 64'(io.io_rsp_valid), 64'd0);
        chk("async_req_ready", 64'(io.io_req_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        s_rdy = 1'b1;
        apply();
        #1;
        chk("post_rst_grant", 64'(io.io_req_ready), 64'b0001);
        cycle();

`ifdef ADDER_ARB_CHAIN_EN
        // two-beat chain on req1 while req2 waits
        do_reset();
        s_valid  = 4'b0110;
        s_lhs[1] = 3;
        s_rhs[1] = 1;
        s_last   = 4'b1101;
        s_lhs[2] = 1;
        s_rhs[2] = 1;
        cycle();
        chk("chain_b0_out", 64'(io.io_rsp_out), 64'd0);
        chk("chain_b0_cout", 64'(io.io_rsp_cout), 64'd1);
        s_lhs[1] = 0;
        s_rhs[1] = 0;
        s_last   = '1;
        apply();
        #1;
        chk("chain_lock", 64'(io.io_req_ready), 64'b0010);
        cycle();
        chk("chain_b1_out", 64'(io.io_rsp_out), 64'd1);
        chk("chain_b1_cout", 64'(io.io_rsp_cout), 64'd0);
        s_valid = 4'b0100;
        apply();
        #1;
        chk("chain_release", 64'(io.io_req_ready), 64'b0100);
        cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
